// File: rtl/bbox_pkg.sv
// bbox_pkg
//   Shared definitions for the bounding-box scan controller slice:
//   the scan sequencer state type, default image geometry and the
//   width helpers used to size coordinate, address and counter ports.
//   No ports (package).

package bbox_pkg;

    // Scan sequencer states. DONE is folded into the DRAIN -> IDLE
    // transition (done is raised on that edge), so the register never
    // rests in it; it is kept as a legal encoding that falls back to IDLE.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_IMG_W = 100;
    localparam int DEF_IMG_H = 100;
    localparam int DEF_PIX_W = 8;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int bits_for(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    function automatic int x_width(input int img_w);
        return bits_for(img_w);
    endfunction

    function automatic int y_width(input int img_h);
        return bits_for(img_h);
    endfunction

    function automatic int addr_width(input int img_w, input int img_h);
        return bits_for(img_w * img_h);
    endfunction

    // The hit counter must reach img_w*img_h inclusive.
    function automatic int cnt_width(input int img_w, input int img_h);
        return bits_for(img_w * img_h + 1);
    endfunction

endpackage

// File: rtl/bbox_rd_pipe.sv
// bbox_rd_pipe
//   Delay line that carries {valid, x, y} of each granted RAM read for
//   exactly RD_LAT cycles, so the coordinates leave the pipe in the same
//   cycle as the matching read data.
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, clears all valid bits
//   in_valid   in   a read was granted this cycle
//   in_x/in_y  in   coordinates of the granted read
//   out_valid  out  coordinate at the end of the pipe is live
//   out_x/y    out  coordinates at the end of the pipe
//   empty_next out  nothing will be left in flight after this cycle's shift

module bbox_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int X_W    = 7,
    parameter int Y_W    = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    output logic           out_valid,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           empty_next
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [X_W-1:0]    x_q [RD_LAT];
    logic [X_W-1:0]    x_d [RD_LAT];
    logic [Y_W-1:0]    y_q [RD_LAT];
    logic [Y_W-1:0]    y_d [RD_LAT];

    // Stage 0 takes the new entry, every other stage takes its predecessor.
    always_comb begin
        vld_d  = '0;
        vld_d[0] = in_valid;
        x_d[0] = in_x;
        y_d[0] = in_y;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            x_d[i]   = x_q[i-1];
            y_d[i]   = y_q[i-1];
        end
    end

    // The last stage drains on this edge, so only the earlier stages and a
    // new entry can keep the pipe occupied next cycle. This lets the
    // sequencer raise done in the cycle right after the final pixel.
    always_comb begin
        empty_next = !in_valid;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (vld_q[i]) begin
                empty_next = 1'b0;
            end
        end
    end

    // Only the valid bits need reset; coordinates are qualified by them.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_x     = x_q[RD_LAT-1];
    assign out_y     = y_q[RD_LAT-1];

endmodule

// File: rtl/bbox_scan_ctrl.sv
// bbox_scan_ctrl
//   Raster-scan sequencer for the bounding-box engine. A start pulse walks
//   the image RAM pixel by pixel through a req/gnt read port, delays the
//   coordinates to line up with the RAM data, and feeds the min/max datapath
//   a clear strobe plus a valid/x/y/hit stream. Object pixels are counted.
// Ports
//   CLOCK_50            in   clock, rising edge
//   reset               in   synchronous active-high reset
//   start               in   one-cycle pulse, accepted only when idle
//   roi_x0/x1/y0/y1     in   inclusive scan window (BBOX_ROI_EN builds only)
//   ram_req/ram_gnt     out/in  read handshake; a read issues on req && gnt
//   ram_addr            out  y*IMG_W + x of the requested pixel
//   ram_rdata           in   pixel data, RD_LAT cycles after a granted read
//   clr                 out  one-cycle pulse at scan begin
//   pix_valid/x/y/hit   out  returning pixel stream, aligned with ram_rdata
//   hit_cnt/found       out  object pixel count of this scan, non-zero flag
//   busy/done           out  scan in progress / last scan complete (level)
// Configuration
//   BBOX_ROI_EN: restricts the scan to the window sampled with start.

module bbox_scan_ctrl
    import bbox_pkg::*;
#(
    parameter int              IMG_W  = DEF_IMG_W,
    parameter int              IMG_H  = DEF_IMG_H,
    parameter int              PIX_W  = DEF_PIX_W,
    parameter logic [PIX_W-1:0] THRESH = PIX_W'(128),
    parameter int              RD_LAT = 1,
    localparam int X_W    = x_width(IMG_W),
    localparam int Y_W    = y_width(IMG_H),
    localparam int ADDR_W = addr_width(IMG_W, IMG_H),
    localparam int CNT_W  = cnt_width(IMG_W, IMG_H)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
`ifdef BBOX_ROI_EN
    input  logic [X_W-1:0]    roi_x0,
    input  logic [X_W-1:0]    roi_x1,
    input  logic [Y_W-1:0]    roi_y0,
    input  logic [Y_W-1:0]    roi_y1,
`endif
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              clr,
    output logic              pix_valid,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              pix_hit,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              found,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             done_q, done_d;

    logic             issue;
    logic             pipe_empty_next;
    logic [X_W-1:0]   x_lo, x_hi;
    logic [Y_W-1:0]   y_lo, y_hi;
    logic             window_ok;

`ifdef BBOX_ROI_EN
    logic [X_W-1:0]    roi_x0_q, roi_x0_d, roi_x1_q, roi_x1_d;
    logic [Y_W-1:0]    roi_y0_q, roi_y0_d, roi_y1_q, roi_y1_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    // The window is captured together with an accepted start so the inputs
    // may change freely while the scan runs.
    always_comb begin
        roi_x0_d = roi_x0_q;
        roi_x1_d = roi_x1_q;
        roi_y0_d = roi_y0_q;
        roi_y1_d = roi_y1_q;
        if (state_q == IDLE && start) begin
            roi_x0_d = roi_x0;
            roi_x1_d = roi_x1;
            roi_y0_d = roi_y0;
            roi_y1_d = roi_y1;
        end
    end

    assign x_lo      = roi_x0_q;
    assign x_hi      = roi_x1_q;
    assign y_lo      = roi_y0_q;
    assign y_hi      = roi_y1_q;
    assign window_ok = (roi_x0_q <= roi_x1_q) && (roi_y0_q <= roi_y1_q) &&
                       (32'(roi_x1_q) < IMG_W) && (32'(roi_y1_q) < IMG_H);

    // Row base moves down one image row whenever x wraps; the single
    // constant multiply only happens once, when the scan is set up.
    always_comb begin
        row_base_d = row_base_q;
        if (clr) begin
            row_base_d = ADDR_W'(y_lo) * ADDR_W'(IMG_W);
        end else if (issue && x_q == x_hi) begin
            row_base_d = row_base_q + ADDR_W'(IMG_W);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            roi_x0_q   <= '0;
            roi_x1_q   <= '0;
            roi_y0_q   <= '0;
            roi_y1_q   <= '0;
            row_base_q <= '0;
        end else begin
            roi_x0_q   <= roi_x0_d;
            roi_x1_q   <= roi_x1_d;
            roi_y0_q   <= roi_y0_d;
            roi_y1_q   <= roi_y1_d;
            row_base_q <= row_base_d;
        end
    end

    assign ram_addr = row_base_q + ADDR_W'(x_q);
`else
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign x_lo      = '0;
    assign x_hi      = X_W'(IMG_W - 1);
    assign y_lo      = '0;
    assign y_hi      = Y_W'(IMG_H - 1);
    assign window_ok = 1'b1;

    // Full rows are scanned in order, so the address is a plain counter.
    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (issue) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign ram_addr = addr_q;
`endif

    // Next-state and scan-position logic. A read is issued only in a granted
    // SCAN cycle; the last granted read moves to DRAIN, and DRAIN leaves for
    // IDLE with done set as soon as the read pipe will be empty.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        hit_cnt_d = hit_cnt_q;
        done_d    = done_q;
        issue     = 1'b0;

        if (pix_hit && hit_cnt_q != CNT_MAX) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    done_d  = 1'b0;
                end
            end
            CLEAR: begin
                hit_cnt_d = '0;
                x_d       = x_lo;
                y_d       = y_lo;
                if (window_ok) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            SCAN: begin
                if (ram_gnt) begin
                    issue = 1'b1;
                    if (x_q == x_hi) begin
                        x_d = x_lo;
                        y_d = y_q + Y_W'(1);
                        if (y_q == y_hi) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            hit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hit_cnt_q <= hit_cnt_d;
            done_q    <= done_d;
        end
    end

    bbox_rd_pipe #(
        .RD_LAT (RD_LAT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_rd_pipe (
        .clk        (CLOCK_50),
        .reset      (reset),
        .in_valid   (issue),
        .in_x       (x_q),
        .in_y       (y_q),
        .out_valid  (pix_valid),
        .out_x      (pix_x),
        .out_y      (pix_y),
        .empty_next (pipe_empty_next)
    );

    assign ram_req = (state_q == SCAN);
    assign clr     = (state_q == CLEAR);
    assign busy    = (state_q == CLEAR) || (state_q == SCAN) || (state_q == DRAIN);
    assign done    = done_q;
    assign pix_hit = pix_valid && (ram_rdata < THRESH);
    assign hit_cnt = hit_cnt_q;
    assign found   = (hit_cnt_q != '0);

endmodule
